// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART TX path: the frame sequencer state
// encoding and the line-mux select codes used by the TX mux and the top level.
package uart_tx_pkg;

    localparam logic [2:0] ST_IDLE_ENC   = 3'b000;
    localparam logic [2:0] ST_START_ENC  = 3'b001;
    localparam logic [2:0] ST_DATA_ENC   = 3'b010;
    localparam logic [2:0] ST_PARITY_ENC = 3'b011;
    localparam logic [2:0] ST_STOP_ENC   = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE   = ST_IDLE_ENC,
        ST_START  = ST_START_ENC,
        ST_DATA   = ST_DATA_ENC,
        ST_PARITY = ST_PARITY_ENC,
        ST_STOP   = ST_STOP_ENC
    } tx_state_t;

    // Line select codes: start bit (0), stop/idle (1), serial data, parity bit
    localparam logic [1:0] MUX_START = 2'b00;
    localparam logic [1:0] MUX_STOP  = 2'b01;
    localparam logic [1:0] MUX_DATA  = 2'b10;
    localparam logic [1:0] MUX_PAR   = 2'b11;

endpackage

// File: rtl/parity_calc.sv
// Combinational parity generator: reduction XOR over the payload, inverted
// for odd parity. Shared between the TX sequencer and the RX parity checker.
module parity_calc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    // Even parity makes the total count of ones even; odd flips that bit
    assign par_bit = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: walks start, data, optional parity and stop,
// drives the serializer enable and line mux select, and holds the frame's
// parity bit captured when the byte request is accepted.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_done,
    output logic                  ser_en,
    output logic [1:0]            mux_sel,
    output logic                  par_bit,
    output logic                  Busy,
    output logic                  tx_done
);

    tx_state_t state_q;
    tx_state_t state_d;
    logic      par_en_q;
    logic      par_calc;
    logic      accept;

    parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_calc (
        .data    (P_DATA),
        .par_typ (PAR_TYP),
        .par_bit (par_calc)
    );

    // A request is only taken while idle; anything during a frame is dropped
    assign accept = (state_q == ST_IDLE) && Data_Valid;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Freeze parity mode and parity bit at accept so mid-frame input changes are harmless
    always_ff @(posedge CLK) begin
        if (RST) begin
            par_en_q <= 1'b0;
            par_bit  <= 1'b0;
        end else if (accept) begin
            par_en_q <= PAR_EN;
            par_bit  <= par_calc;
        end
    end

    // Next-state logic and Moore output decode
    always_comb begin
        state_d = state_q;
        mux_sel = MUX_STOP;
        ser_en  = 1'b0;
        Busy    = 1'b0;
        tx_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Data_Valid) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                mux_sel = MUX_START;
                Busy    = 1'b1;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                mux_sel = MUX_DATA;
                ser_en  = 1'b1;
                Busy    = 1'b1;
                if (ser_done) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                mux_sel = MUX_PAR;
                Busy    = 1'b1;
                state_d = ST_STOP;
            end
            ST_STOP: begin
                Busy    = 1'b1;
                tx_done = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for the UART TX frame sequencer with a small serializer
// model closing the ser_en / ser_done loop and a line mux decode.
module tb_uart_tx_ctrl;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       ser_done;
    logic       ser_en;
    logic [1:0] mux_sel;
    logic       par_bit;
    logic       Busy;
    logic       tx_done;

    int n_chk  = 0;
    int n_pass = 0;

    uart_tx_ctrl #(
        .DATA_WIDTH (8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_done   (ser_done),
        .ser_en     (ser_en),
        .mux_sel    (mux_sel),
        .par_bit    (par_bit),
        .Busy       (Busy),
        .tx_done    (tx_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Serializer model: loads while not busy, shifts LSB first on ser_en
    logic [7:0] sh;
    logic [2:0] cnt;
    logic       line;

    always @(posedge CLK) begin
        if (!Busy) begin
            sh  <= P_DATA;
            cnt <= 3'd0;
        end else if (ser_en) begin
            sh  <= {1'b0, sh[7:1]};
            cnt <= cnt + 3'd1;
        end
    end

    assign ser_done = ser_en && (cnt == 3'd7);

    always_comb begin
        case (mux_sel)
            2'b00:   line = 1'b0;
            2'b01:   line = 1'b1;
            2'b10:   line = sh[0];
            default: line = par_bit;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Caller has the request already presented in cycle 0; checks cycles 1..L+1
    task automatic run_frame(input string nm, input logic [7:0] d, input bit pen,
                             input bit exp_par, input bit keep_dv,
                             input logic [7:0] nxt, input bit toggle);
        int         len;
        logic [1:0] exp_mux;
        len = pen ? 11 : 10;
        for (int k = 1; k <= len + 1; k++) begin
            step();
            if (k == 1)      exp_mux = 2'b00;
            else if (k <= 9) exp_mux = 2'b10;
            else if (k == 10 && pen) exp_mux = 2'b11;
            else             exp_mux = 2'b01;
            chk($sformatf("%s c%0d mux_sel", nm, k), 32'(mux_sel), 32'(exp_mux));
            chk($sformatf("%s c%0d Busy", nm, k), 32'(Busy), 32'(k <= len));
            chk($sformatf("%s c%0d ser_en", nm, k), 32'(ser_en), 32'(k >= 2 && k <= 9));
            chk($sformatf("%s c%0d tx_done", nm, k), 32'(tx_done), 32'(k == len));
            if (k == 1) begin
                chk($sformatf("%s par_bit", nm), 32'(par_bit), 32'(exp_par));
                chk($sformatf("%s start line", nm), 32'(line), 32'd0);
            end
            if (k >= 2 && k <= 9)
                chk($sformatf("%s c%0d line", nm, k), 32'(line), 32'(d[k-2]));
            if (pen && k == 10)
                chk($sformatf("%s parity line", nm), 32'(line), 32'(exp_par));
            if (k == len) begin
                chk($sformatf("%s stop line", nm), 32'(line), 32'd1);
                chk($sformatf("%s par_bit held", nm), 32'(par_bit), 32'(exp_par));
            end
            if (k == 1 && !keep_dv) Data_Valid = 1'b0;
            if (toggle && k >= 3 && k <= 8) begin
                PAR_EN  = ~PAR_EN;
                PAR_TYP = ~PAR_TYP;
                P_DATA  = P_DATA ^ 8'hFF;
            end
        end
        if (keep_dv) P_DATA = nxt;
        else         Data_Valid = 1'b0;
    endtask

    initial begin
        RST        = 1'b1;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;

        // Reset
        step();
        step();
        chk("rst Busy", 32'(Busy), 32'd0);
        chk("rst ser_en", 32'(ser_en), 32'd0);
        chk("rst mux_sel", 32'(mux_sel), 32'd1);
        chk("rst par_bit", 32'(par_bit), 32'd0);
        chk("rst tx_done", 32'(tx_done), 32'd0);

        // Reset wins over a simultaneous request
        Data_Valid = 1'b1;
        P_DATA     = 8'h07;
        step();
        chk("rst prio Busy", 32'(Busy), 32'd0);
        chk("rst prio mux_sel", 32'(mux_sel), 32'd1);
        chk("rst prio par_bit", 32'(par_bit), 32'd0);
        RST        = 1'b0;
        Data_Valid = 1'b0;
        step();
        chk("idle Busy", 32'(Busy), 32'd0);

        // No parity, A5
        P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        run_frame("np_a5", 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step();

        // Even parity A5 -> 0, odd parity A5 -> 1, even parity 07 -> 1
        P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        run_frame("ev_a5", 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_Valid = 1'b1;
        run_frame("od_a5", 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        P_DATA = 8'h07; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        run_frame("ev_07", 8'h07, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        step();

        // Back-to-back frames with the request held high
        P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        run_frame("b2b_3c", 8'h3C, 1'b0, 1'b0, 1'b1, 8'h81, 1'b0);
        run_frame("b2b_81", 8'h81, 1'b0, 1'b0, 1'b1, 8'hF1, 1'b0);
        run_frame("b2b_f1", 8'hF1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        step();

        // Input churn during DATA must not disturb the frame
        P_DATA = 8'hC3; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_Valid = 1'b1;
        run_frame("churn_c3", 8'hC3, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        step();

        // Reset in the 5th DATA cycle, then a clean frame
        P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            Data_Valid = 1'b0;
        end
        chk("mid ser_en before rst", 32'(ser_en), 32'd1);
        RST = 1'b1;
        step();
        chk("mid rst Busy", 32'(Busy), 32'd0);
        chk("mid rst ser_en", 32'(ser_en), 32'd0);
        chk("mid rst mux_sel", 32'(mux_sel), 32'd1);
        chk("mid rst tx_done", 32'(tx_done), 32'd0);
        chk("mid rst par_bit", 32'(par_bit), 32'd0);
        RST = 1'b0;
        P_DATA = 8'h5A; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_Valid = 1'b1;
        run_frame("post_rst_5a", 8'h5A, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
